// File: rtl/fde_fetch_unit_if.sv
// Program memory read port between the fetch unit (master) and program memory (slave).
interface fde_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fde_fetch_unit.sv
// Fetch responder for the fetch/decode/execute sequencer: reads one instruction byte per
// fetch phase over a req/ack port, owns PC and IR, and stalls the sequencer until served.
module fde_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [7:0]            NOP_OPCODE = 8'h00,
    parameter int unsigned           TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch,
    input  logic                  decode,
    input  logic                  execute,
    output logic                  fde_enable,
    fde_fetch_unit_if.master      bus,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [7:0]            instr,
    output logic                  instr_valid,
    output logic                  fetch_err
);

    localparam int unsigned       CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0]   CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]            instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_hit;

    // The decode strobe carries no state; kept only to complete the sequencer interface.
    logic unused_decode;
    assign unused_decode = decode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NOP_OPCODE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = done_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        // One-hot strobes keep a jump and an ack from landing on the same edge.
        if (execute && pc_load) begin
            pc_d = pc_target;
        end

        unique case (state_q)
            StIdle: begin
                if (fetch && !done_q) begin
                    state_d = StReq;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    instr_d = NOP_OPCODE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!fetch) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        bus.mem_req  = (state_q == StReq);
        bus.mem_addr = pc_q;
        fde_enable   = !(fetch && !done_q);
        pc           = pc_q;
        instr        = instr_q;
        instr_valid  = valid_q;
        fetch_err    = err_q;
    end

endmodule

// File: tb/tb_fde_fetch_unit.sv
// Randomized scoreboard bench for fde_fetch_unit: a driver plays the sequencer, a memory
// responder inserts wait states, and a monitor checks each completed fetch phase.
module tb_fde_fetch_unit;

    localparam int unsigned AW  = 8;
    localparam int unsigned TO  = 4;
    localparam logic [7:0]  NOP = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch = 1'b0;
    logic          decode = 1'b0;
    logic          execute = 1'b0;
    logic          pc_load = 1'b0;
    logic [AW-1:0] pc_target = '0;
    logic          fde_enable;
    logic [AW-1:0] pc;
    logic [7:0]    instr;
    logic          instr_valid;
    logic          fetch_err;

    fde_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

    fde_fetch_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (8'h00),
        .NOP_OPCODE (NOP),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch       (fetch),
        .decode      (decode),
        .execute     (execute),
        .fde_enable  (fde_enable),
        .bus         (bus),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] instr;
        logic [7:0] pc;
        logic       valid;
        logic       err;
        int         req_cycles;
        int         stall_cycles;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [256];
    logic [7:0] model_pc = 8'h00;
    int         cur_wait = 100;
    int         req_age = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks after cur_wait request cycles, junk acks while idle must be ignored.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (req_age == cur_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'($urandom);
            end
            req_age++;
        end else begin
            req_age       = 0;
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
        end
    end

    int         req_cnt = 0;
    int         stall_cnt = 0;
    logic [7:0] req_addr = 8'h00;
    bit         addr_moved = 1'b0;
    bit         in_stall = 1'b0;

    always @(negedge clk) begin
        bit   done_now;
        exp_t e;
        #1;
        if (mon_en) begin
            done_now = fetch && fde_enable && in_stall;
            if (bus.mem_req) begin
                if (req_cnt == 0) req_addr = bus.mem_addr;
                else if (bus.mem_addr != req_addr) addr_moved = 1'b1;
                req_cnt++;
            end
            if (fetch && !fde_enable) begin
                stall_cnt++;
                in_stall = 1'b1;
            end
            if (!fetch) check("enable_outside_fetch", 32'(fde_enable), 32'd1);
            if (done_now) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got completion expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr", 32'(req_addr), 32'(e.addr));
                    check("addr_stable", 32'(addr_moved), 32'd0);
                    check("instr", 32'(instr), 32'(e.instr));
                    check("instr_valid", 32'(instr_valid), 32'(e.valid));
                    check("pc", 32'(pc), 32'(e.pc));
                    check("fetch_err", 32'(fetch_err), 32'(e.err));
                    check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
                end
                req_cnt    = 0;
                stall_cnt  = 0;
                addr_moved = 1'b0;
                in_stall   = 1'b0;
            end else if (fetch_err) begin
                check("spurious_fetch_err", 32'(fetch_err), 32'd0);
            end
        end
    end

    // One full fetch/decode/execute instruction; decode-phase pc_load must be ignored.
    task automatic run_instr(input int w, input bit ld, input logic [7:0] tgt);
        exp_t e;
        int   n;
        e.addr = model_pc;
        if (w < int'(TO)) begin
            e.instr        = mem[model_pc];
            e.valid        = 1'b1;
            e.err          = 1'b0;
            e.pc           = model_pc + 8'd1;
            e.req_cycles   = w + 1;
            e.stall_cycles = w + 2;
        end else begin
            e.instr        = NOP;
            e.valid        = 1'b0;
            e.err          = 1'b1;
            e.pc           = model_pc;
            e.req_cycles   = int'(TO);
            e.stall_cycles = int'(TO) + 1;
        end
        exp_q.push_back(e);
        model_pc = e.pc;
        cur_wait = w;

        @(negedge clk);
        fetch = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (fde_enable) break;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL fetch_stall_bound: got no fde_enable expected within 40 cycles");
        end
        @(negedge clk);
        fetch     = 1'b0;
        decode    = 1'b1;
        pc_load   = 1'($urandom_range(0, 1));
        pc_target = 8'($urandom);
        @(negedge clk);
        decode    = 1'b0;
        execute   = 1'b1;
        pc_load   = ld;
        pc_target = tgt;
        if (ld) model_pc = tgt;
        @(negedge clk);
        execute = 1'b0;
        pc_load = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0]        = 8'hA5;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset_pc", 32'(pc), 32'h00);
        check("reset_instr", 32'(instr), 32'(NOP));
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_enable", 32'(fde_enable), 32'd1);
        check("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check("reset_fetch_err", 32'(fetch_err), 32'd0);

        // Reset asserted in the middle of a request from pc=05.
        execute   = 1'b1;
        pc_load   = 1'b1;
        pc_target = 8'h05;
        @(negedge clk);
        execute = 1'b0;
        pc_load = 1'b0;
        #1;
        check("jump_pre_reset", 32'(pc), 32'h05);
        cur_wait = 100;
        @(negedge clk);
        fetch = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("mid_req_mem_req", 32'(bus.mem_req), 32'd1);
        check("mid_req_mem_addr", 32'(bus.mem_addr), 32'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mem_req", 32'(bus.mem_req), 32'd0);
        check("async_reset_pc", 32'(pc), 32'h00);
        fetch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_pc", 32'(pc), 32'h00);
        check("post_reset_instr", 32'(instr), 32'(NOP));
        check("post_reset_valid", 32'(instr_valid), 32'd0);
        check("post_reset_enable", 32'(fde_enable), 32'd1);
        model_pc = 8'h00;
        mon_en   = 1'b1;

        run_instr(0, 1'b0, 8'h00);   // zero-wait, A5 at address 0
        run_instr(3, 1'b0, 8'h00);   // three wait states
        run_instr(10, 1'b1, 8'h40);  // timeout, then jump
        run_instr(0, 1'b1, 8'hFF);   // fetch at 40, then jump to FF
        run_instr(1, 1'b0, 8'h00);   // fetch at FF wraps pc to 00
        run_instr(0, 1'b0, 8'h00);
        for (int i = 0; i < 150; i++) begin
            run_instr(int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fde_fetch_unit.md
Name: fde_fetch_unit

Overview:
- Responder side of the fetch/decode/execute phase sequencer: consumes the one-hot `fetch`/`decode`/`execute` strobes and answers each fetch phase.
- It reads one 8-bit instruction byte from program memory through a req/ack handshake, holds the program counter and the instruction register, and supports PC loads (jumps) during execute.
- It stalls the sequencer through `fde_enable` until the fetched byte is captured.
- It sits between the phase sequencer and the program memory port.

Parameters:
- ADDR_WIDTH, 8, program counter / memory address width.
- RESET_PC, 0, PC value after reset.
- NOP_OPCODE, 8'h00, instruction register value after reset and after a timed-out fetch.
- TIMEOUT, 16, max cycles `mem_req` is held without `mem_ack` before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch  input  1  sequencer fetch-phase strobe.
- decode  input  1  sequencer decode-phase strobe; informational only, no effect on state.
- execute  input  1  sequencer execute-phase strobe.
- fde_enable  output  1  advance permission back to the sequencer.
- mem_req  output  1  program memory read request.
- mem_addr  output  ADDR_WIDTH  read address, equals `pc` while `mem_req`=1.
- mem_ack  input  1  read data valid; sampled only while `mem_req`=1.
- mem_rdata  input  8  read data, captured on the edge where `mem_req`&`mem_ack`.
- pc_load  input  1  load PC from `pc_target`; honoured only while `execute`=1.
- pc_target  input  ADDR_WIDTH  jump target.
- pc  output  ADDR_WIDTH  current program counter.
- instr  output  8  instruction register.
- instr_valid  output  1  `instr` holds a byte captured from memory.
- fetch_err  output  1  one-cycle pulse on fetch timeout.

Behaviour:
- **Reset** (async, `rst_n`=0): state IDLE, `pc`=RESET_PC, `instr`=NOP_OPCODE, `instr_valid`=0, `fetch_err`=0, `done`=0, timeout count=0. `mem_req`=0 immediately, including mid-request.
- **States:** IDLE, REQ. `mem_req` = (state==REQ). `mem_addr`=`pc`.
- **Internal `done` flag:** marks the current fetch phase as already served. It is cleared on any edge where `fetch`=0.
- **Stall:** `fde_enable` = !(`fetch` & !`done`), combinational. It is always 1 in decode and execute phases.
- **IDLE -> REQ:** on an edge with `fetch`=1 and `done`=0. The same edge clears `instr_valid` and the timeout count.
- **REQ, ack:** on an edge with `mem_ack`=1:
  - `instr` <= `mem_rdata`, `instr_valid` <= 1.
  - `pc` <= `pc`+1, wrapping modulo 2^ADDR_WIDTH.
  - `done` <= 1, return to IDLE.
- **REQ, timeout:** TIMEOUT>0 and count reaches TIMEOUT-1 with no ack:
  - Abort: `instr` <= NOP_OPCODE, `instr_valid` stays 0.
  - `pc` is unchanged, `fetch_err` pulses 1 for one cycle.
  - `done` <= 1, return to IDLE.
- **REQ, otherwise:** count+1, `mem_req` held, address stable.
- **Minimum fetch phase:** 3 cycles with zero-wait memory.
  - c0: `fetch` rises, IDLE, `fde_enable`=0.
  - c1: REQ, `mem_req`=1, `mem_ack`=1.
  - c2: `instr` valid, `done`=1, `fde_enable`=1.
  - The sequencer leaves fetch on the c3 edge.
  - Each memory wait cycle adds one cycle.
- **PC load:** on an edge with `execute`=1 and `pc_load`=1, `pc` <= `pc_target`. `pc_load` is ignored in fetch and decode.
- **No double fetch:** the one-hot strobes make a PC load and an ack on the same edge impossible. `fetch` staying high after `done` never issues a second request.
- **Illegal input:** `mem_ack` while `mem_req`=0 is ignored.

Test Plan:
- **Reset:** assert `rst_n`=0 mid-REQ (`pc`=8'h05). Expect `mem_req`=0 immediately. After release: `pc`=0, `instr`=8'h00, `instr_valid`=0, `fde_enable`=1 while `fetch`=0.
- **Zero-wait fetch:** memory returns 8'hA5 at addr 0 with ack in the request cycle. Expect `fde_enable`=0 for exactly 2 cycles, then `instr`=8'hA5, `instr_valid`=1, `pc`=1, exactly one `mem_req` cycle.
- **Wait states:** ack delayed 3 cycles. Expect `mem_req`/`mem_addr` stable for 4 cycles, stall length 5 cycles, `pc` increments once.
- **Timeout:** TIMEOUT=4, never ack. Expect `mem_req` high for 4 cycles, `fetch_err` pulse of 1 cycle, `instr`=NOP_OPCODE, `pc` unchanged, `fde_enable`=1 after abort.
- **Jump:** `pc_load`=1, `pc_target`=8'h40 during execute. Expect `pc`=8'h40 and the next `mem_addr`=8'h40. The same `pc_load` during decode is ignored.
- **Wrap:** `pc`=8'hFF, successful fetch. Expect `pc`=8'h00 afterwards.
